// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data memory between the pipeline MEM stage
// (CPU port) and a DMA/debug loader (DMA port).
//
// The CPU wins by default. A saturating starvation counter forces one DMA beat
// ahead of the CPU after STARVE_MAX consecutive denied DMA cycles. Once a
// multi-beat DMA burst is granted it owns the memory until its last beat, the
// BURST_MAX beat cap, or the DMA dropping its request.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   cpu_req/we/addr/wdata/func3  CPU access from the EX/MEM register
//   cpu_rdata                  CPU load data (combinational, zero latency)
//   cpu_stall                  CPU request lost arbitration this cycle
//   dma_req/we/addr/wdata/last   DMA beat request
//   dma_gnt                    DMA beat accepted this cycle
//   dma_rvalid, dma_rdata      registered DMA read data, one cycle after grant
//   mem_rd/wr/addr/wdata/func3   data memory command
//   mem_rdata                  data memory read data (combinational read)
//
// state     | meaning
// CPU_OWN   | CPU has priority; DMA wins only when CPU idle or DMA starved
// DMA_BURST | DMA owns memory for the remaining beats of a burst
module dmem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int STARVE_MAX = 4,
  parameter int BURST_MAX  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [DM_ADDRESS-1:0] cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  input  logic [2:0]            cpu_func3,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [DM_ADDRESS-1:0] dma_addr,
  input  logic [DATA_W-1:0]     dma_wdata,
  input  logic                  dma_last,
  output logic                  dma_gnt,
  output logic                  dma_rvalid,
  output logic [DATA_W-1:0]     dma_rdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_func3,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam logic [0:0] CPU_OWN   = 1'b0;
  localparam logic [0:0] DMA_BURST = 1'b1;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [4:0] BEAT_LAST  = 5'(BURST_MAX - 1);
  localparam logic       MULTI_BEAT = (BURST_MAX > 1);

  logic [0:0]        state_q, state_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic [4:0]        beat_cnt_q, beat_cnt_d;
  logic              dma_rvalid_q;
  logic [DATA_W-1:0] dma_rdata_q;

  logic starved;
  logic g_dma;
  logic g_cpu;

  // Grants are forced low during reset so no memory command escapes.
  always_comb begin
    starved = (starve_cnt_q == STARVE_LIM);
    g_dma   = 1'b0;
    if (!reset) begin
      if (state_q == DMA_BURST) g_dma = dma_req;
      else                      g_dma = dma_req && (!cpu_req || starved);
    end
    g_cpu = !reset && cpu_req && !g_dma;
  end

  assign dma_gnt    = g_dma;
  assign cpu_stall  = cpu_req && g_dma;
  assign cpu_rdata  = (g_cpu && !cpu_we) ? mem_rdata : '0;
  assign dma_rvalid = dma_rvalid_q;
  assign dma_rdata  = dma_rdata_q;

  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_func3 = 3'b000;
    if (g_dma) begin
      mem_rd    = !dma_we;
      mem_wr    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_func3 = 3'b010;
    end else if (g_cpu) begin
      mem_rd    = !cpu_we;
      mem_wr    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_func3 = cpu_func3;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      CPU_OWN: begin
        if (g_dma && !dma_last && MULTI_BEAT) begin
          state_d    = DMA_BURST;
          beat_cnt_d = 5'd1;
        end
      end
      DMA_BURST: begin
        // Dropping dma_req abandons the burst and hands memory back at once.
        if (!dma_req || dma_last || (beat_cnt_q == BEAT_LAST)) begin
          state_d    = CPU_OWN;
          beat_cnt_d = 5'd0;
        end else begin
          beat_cnt_d = beat_cnt_q + 5'd1;
        end
      end
      default: begin
        state_d    = CPU_OWN;
        beat_cnt_d = 5'd0;
      end
    endcase
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!dma_req || g_dma)     starve_cnt_d = 4'd0;
    else if (cpu_req && !starved) starve_cnt_d = starve_cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CPU_OWN;
      starve_cnt_q <= 4'd0;
      beat_cnt_q   <= 5'd0;
      dma_rvalid_q <= 1'b0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      dma_rvalid_q <= g_dma && !dma_we;
      if (g_dma && !dma_we) dma_rdata_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed per-cycle stimulus pushes the expected
// CPU-served, DMA-grant and DMA-read-return events (with the cycle each must
// appear in) into queues; a negedge monitor pops and compares them.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [8:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic [2:0]  cpu_func3;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_we;
  logic [8:0]  dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_last;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] dma_rdata;
  logic        mem_rd, mem_wr;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_func3;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(32), .DM_ADDRESS(9), .STARVE_MAX(4), .BURST_MAX(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_func3(cpu_func3), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_last(dma_last), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_func3(mem_func3), .mem_rdata(mem_rdata)
  );

  typedef struct {
    int          cyc;
    logic        we;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] data;
    logic        stall;
  } ev_t;

  ev_t q_cpu[$];
  ev_t q_dma[$];
  ev_t q_rv[$];

  int cyc = 0;
  int tests = 0;
  int failed = 0;
  bit done = 1'b0;
  bit chk_rd0 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [8:0] a,
                         input logic [31:0] wd, input logic [2:0] f3);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_func3 = f3;
  endtask

  task automatic set_dma(input logic req, input logic we, input logic [8:0] a,
                         input logic [31:0] wd, input logic last);
    dma_req = req; dma_we = we; dma_addr = a; dma_wdata = wd; dma_last = last;
  endtask

  task automatic idle();
    set_cpu(1'b0, 1'b0, 9'h0, 32'h0, 3'b000);
    set_dma(1'b0, 1'b0, 9'h0, 32'h0, 1'b0);
  endtask

  task automatic exp_cpu(input logic [31:0] rd);
    ev_t e;
    e.cyc = cyc; e.we = cpu_we; e.addr = cpu_addr; e.wdata = cpu_wdata;
    e.f3 = cpu_func3; e.data = rd; e.stall = 1'b0;
    q_cpu.push_back(e);
  endtask

  task automatic exp_dma(input logic stall);
    ev_t e;
    e.cyc = cyc; e.we = dma_we; e.addr = dma_addr; e.wdata = dma_wdata;
    e.f3 = 3'b010; e.data = 32'h0; e.stall = stall;
    q_dma.push_back(e);
  endtask

  task automatic exp_rv(input logic [31:0] rd);
    ev_t e;
    e.cyc = cyc + 1; e.we = 1'b0; e.addr = 9'h0; e.wdata = 32'h0;
    e.f3 = 3'b000; e.data = rd; e.stall = 1'b0;
    q_rv.push_back(e);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares every DUT output event against the scoreboard queues.
  always @(negedge clk) begin
    ev_t e;
    bit  served;
    served = cpu_req && !cpu_stall && !reset;
    if (served) begin
      if (q_cpu.size() == 0) chk("cpu_unexpected", 128'(cyc), 128'(-1));
      else begin
        e = q_cpu.pop_front();
        chk("cpu_access",
            {16'h0, 32'(cyc), mem_rd, mem_wr, mem_addr, mem_wdata, mem_func3, cpu_rdata, cpu_stall, dma_gnt},
            {16'h0, 32'(e.cyc), !e.we, e.we, e.addr, e.wdata, e.f3, e.data, 1'b0, 1'b0});
      end
    end
    if (dma_gnt) begin
      if (q_dma.size() == 0) chk("dma_unexpected", 128'(cyc), 128'(-1));
      else begin
        e = q_dma.pop_front();
        chk("dma_grant",
            {16'h0, 32'(cyc), mem_rd, mem_wr, mem_addr, mem_wdata, mem_func3, cpu_rdata, cpu_stall, dma_gnt},
            {16'h0, 32'(e.cyc), !e.we, e.we, e.addr, e.wdata, 3'b010, 32'h0, e.stall, 1'b1});
      end
    end
    if (!served && !dma_gnt) begin
      chk("idle_outputs",
          {48'h0, mem_rd, mem_wr, mem_addr, mem_wdata, mem_func3, cpu_rdata, cpu_stall, dma_gnt},
          128'h0);
    end
    if (dma_rvalid) begin
      if (q_rv.size() == 0) chk("rvalid_unexpected", 128'(cyc), 128'(-1));
      else begin
        e = q_rv.pop_front();
        chk("dma_rdata", {64'h0, 32'(cyc), dma_rdata}, {64'h0, 32'(e.cyc), e.data});
      end
    end
    if (chk_rd0) chk("reset_dma_rdata", {96'h0, dma_rdata}, 128'h0);
    if (done) begin
      chk("cpu_events_left", 128'(q_cpu.size()), 128'h0);
      chk("dma_events_left", 128'(q_dma.size()), 128'h0);
      chk("rv_events_left", 128'(q_rv.size()), 128'h0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle();
    mem_rdata = 32'h5555_5555;
    // Both requesters active during reset: nothing may be granted.
    set_cpu(1'b1, 1'b0, 9'h010, 32'h0, 3'b010);
    set_dma(1'b1, 1'b0, 9'h020, 32'h0, 1'b0);
    step(); step();

    reset = 1'b0; idle(); chk_rd0 = 1'b1;
    step(); chk_rd0 = 1'b0;

    // CPU-only read and write.
    set_cpu(1'b1, 1'b0, 9'h010, 32'h0, 3'b010); mem_rdata = 32'hDEAD_BEEF;
    exp_cpu(32'hDEAD_BEEF); step();
    set_cpu(1'b1, 1'b1, 9'h014, 32'hCAFE_F00D, 3'b001); mem_rdata = 32'h1111_1111;
    exp_cpu(32'h0); step();

    // DMA-only single-beat write; no read return follows.
    idle(); set_dma(1'b1, 1'b1, 9'h020, 32'h1234_5678, 1'b1); mem_rdata = 32'h0;
    exp_dma(1'b0); step();

    // Contention: CPU wins 4 cycles, DMA forced on the 5th, CPU wins again.
    for (int k = 0; k < 6; k++) begin
      set_cpu(1'b1, 1'b0, 9'h030, 32'h0, 3'b100);
      set_dma(1'b1, 1'b0, 9'h040, 32'h0, 1'b1);
      mem_rdata = 32'hC000_0000 + 32'(k);
      if (k == 4) begin exp_dma(1'b1); exp_rv(32'hC000_0004); end
      else exp_cpu(32'hC000_0000 + 32'(k));
      step();
    end
    idle(); step();

    // Burst cap: 4 CPU cycles, then exactly 8 DMA read beats, then CPU.
    for (int j = 0; j < 13; j++) begin
      set_cpu(1'b1, 1'b0, 9'h050, 32'h0, 3'b010);
      set_dma(1'b1, 1'b0, 9'(9'h100 + 4 * j), 32'h0, 1'b0);
      mem_rdata = 32'hB000_0000 + 32'(j);
      if (j >= 4 && j <= 11) begin exp_dma(1'b1); exp_rv(32'hB000_0000 + 32'(j)); end
      else exp_cpu(32'hB000_0000 + 32'(j));
      step();
    end
    idle(); step();

    // Burst abort after 3 write beats; CPU served at once, state back to CPU_OWN.
    set_dma(1'b1, 1'b1, 9'h080, 32'hA000_0000, 1'b0); exp_dma(1'b0); step();
    set_cpu(1'b1, 1'b0, 9'h060, 32'h0, 3'b010);
    set_dma(1'b1, 1'b1, 9'h084, 32'hA000_0001, 1'b0); exp_dma(1'b1); step();
    set_dma(1'b1, 1'b1, 9'h088, 32'hA000_0002, 1'b0); exp_dma(1'b1); step();
    set_dma(1'b0, 1'b0, 9'h0, 32'h0, 1'b0); mem_rdata = 32'h6060_6060;
    exp_cpu(32'h6060_6060); step();
    set_cpu(1'b1, 1'b0, 9'h064, 32'h0, 3'b010);
    set_dma(1'b1, 1'b1, 9'h090, 32'hA000_0003, 1'b1); mem_rdata = 32'h6464_6464;
    exp_cpu(32'h6464_6464); step();
    idle(); step();

    // Reset in the cycle of beat 2 of a read burst.
    set_dma(1'b1, 1'b0, 9'h0C0, 32'h0, 1'b0); mem_rdata = 32'hE0E0_E0E0;
    exp_dma(1'b0); exp_rv(32'hE0E0_E0E0); step();
    reset = 1'b1;
    set_cpu(1'b1, 1'b0, 9'h070, 32'h0, 3'b010);
    set_dma(1'b1, 1'b0, 9'h0C4, 32'h0, 1'b0); mem_rdata = 32'h1212_1212; step();
    reset = 1'b0; mem_rdata = 32'h7070_7070;
    exp_cpu(32'h7070_7070); step();

    idle(); step(); step();
    done = 1'b1;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory between two requesters: the pipeline MEM stage (port CPU) and a DMA/debug loader (port DMA).
- CPU has default priority.
- A starvation counter guarantees DMA forward progress, and granted DMA bursts hold ownership until their last beat.
- Sits between the EX/MEM register outputs and the data memory; asserts cpu_stall back to the pipeline hazard logic when the CPU loses arbitration.

Parameters:
- DATA_W, 32, data width.
- DM_ADDRESS, 9, data memory byte-address width.
- STARVE_MAX, 4, consecutive denied DMA cycles before DMA is forced ahead of the CPU (1..15).
- BURST_MAX, 8, maximum DMA beats per ownership period (1..16).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cpu_req  in  1  CPU access request (MemRead|MemWrite)
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  DM_ADDRESS  CPU address
- cpu_wdata  in  DATA_W  CPU store data
- cpu_func3  in  3  CPU access size/sign code
- cpu_rdata  out  DATA_W  CPU load data (combinational)
- cpu_stall  out  1  CPU request not served this cycle
- dma_req  in  1  DMA beat request
- dma_we  in  1  1=write, 0=read
- dma_addr  in  DM_ADDRESS  DMA address
- dma_wdata  in  DATA_W  DMA write data
- dma_last  in  1  current beat is the final beat of the burst
- dma_gnt  out  1  DMA beat accepted this cycle
- dma_rvalid  out  1  registered read data valid
- dma_rdata  out  DATA_W  registered DMA read data
- mem_rd  out  1  memory read enable
- mem_wr  out  1  memory write enable
- mem_addr  out  DM_ADDRESS  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_func3  out  3  memory size code
- mem_rdata  in  DATA_W  memory read data (combinational read)

Behaviour:
- Reset and clocking:
  - One clock domain; reset is synchronous and active-high.
  - On reset: state=CPU_OWN, starve_cnt=0, beat_cnt=0, dma_rvalid=0, dma_rdata=0.
  - While reset is high, dma_gnt, cpu_stall, mem_rd and mem_wr are all 0.
- States: CPU_OWN, DMA_BURST.
- Grant, combinational:
  - g_dma = DMA_BURST ? dma_req : (dma_req && (!cpu_req || starve_cnt==STARVE_MAX)).
  - g_cpu = cpu_req && !g_dma.
- Derived outputs:
  - dma_gnt = g_dma.
  - cpu_stall = cpu_req && g_dma.
  - A CPU request is never dropped: it is served on the first cycle g_cpu=1.
- Memory mux:
  - g_cpu: mem_* driven from cpu_*, with mem_rd=!cpu_we and mem_wr=cpu_we.
  - g_dma: mem_* driven from dma_*, with mem_func3=3'b010 (word).
  - Neither granted: mem_rd=mem_wr=0, mem_addr=0, mem_wdata=0, mem_func3=0.
- Read data:
  - cpu_rdata = mem_rdata when g_cpu && !cpu_we, else 0. Zero latency, matching the existing MEM→WB timing.
  - DMA read beat: dma_rvalid=1 and dma_rdata=mem_rdata one cycle after the grant.
  - dma_rvalid=0 after a write beat or a cycle with no DMA grant; dma_rdata holds its last value.
- starve_cnt (0..STARVE_MAX, saturating):
  - Increments when dma_req && cpu_req && !g_dma.
  - Clears on any g_dma cycle or whenever dma_req=0.
- Transitions from CPU_OWN:
  - g_dma && !dma_last && BURST_MAX>1 → DMA_BURST, beat_cnt=1.
  - Otherwise remain in CPU_OWN.
- Transitions from DMA_BURST:
  - g_dma && (dma_last || beat_cnt==BURST_MAX-1) → CPU_OWN, beat_cnt=0.
  - g_dma otherwise → beat_cnt+1.
  - dma_req=0 → CPU_OWN, beat_cnt=0; no grant that cycle (burst abandoned).
- DMA_BURST ownership: the CPU is stalled for every cycle it requests while DMA beats are granted.
- Simultaneous events: with dma_last and a fresh cpu_req in the same cycle, the DMA beat completes and the CPU is served next cycle.
- BURST_MAX=1: every DMA grant is single-beat and the FSM never leaves CPU_OWN.
- Reset mid-burst: state returns to CPU_OWN immediately; any pending dma_rvalid is cleared.

Test Plan:
- CPU only: cpu_req=1, cpu_we=0, addr=0x010, mem_rdata=0xDEADBEEF → mem_rd=1, cpu_rdata=0xDEADBEEF same cycle, cpu_stall=0, dma_gnt=0.
- DMA only, single beat: dma_req=1, dma_we=1, addr=0x020, wdata=0x12345678, dma_last=1 → mem_wr=1, mem_func3=010, dma_gnt=1, state stays CPU_OWN, dma_rvalid=0 next cycle.
- Contention/starvation: cpu_req and dma_req held high, STARVE_MAX=4 → CPU granted cycles 0–3 with cpu_stall=0; cycle 4 dma_gnt=1 and cpu_stall=1; starve_cnt returns to 0.
- Burst cap: DMA read burst, dma_last never asserted, BURST_MAX=8, cpu_req=1 throughout → exactly 8 consecutive dma_gnt; cpu_stall=1 for those 8 cycles; CPU served on cycle 9; 8 dma_rvalid pulses, each one cycle late.
- Burst abort: dma_req drops after beat 3 of a burst → no grant that cycle, state CPU_OWN next cycle, a pending cpu_req is served immediately.
- Reset mid-burst: reset asserted on beat 2 → next cycle dma_gnt=0, dma_rvalid=0, state CPU_OWN; after deassert a CPU request is served without stall.
